// File: rtl/bru_pkg.sv
// Shared types and helpers for the branch resolve unit.
// Optional feature macro: BRU_STATS_EN (resolution/mispredict counters).
package bru_pkg;

  localparam int unsigned BRU_DEPTH_DEF        = 4;
  localparam int unsigned BRU_FLUSH_CYCLES_DEF = 2;
  localparam int unsigned BRU_IDX_W_DEF        = 7;

  // One fetch-time prediction waiting for its execute-stage outcome.
  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
  } bru_entry_t;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } bru_state_t;

  // Wrong direction, or right "taken" direction but wrong target.
  function automatic logic bru_is_mispredict(input bru_entry_t e,
                                             input logic act_taken,
                                             input logic [31:0] act_target);
    return (act_taken != e.taken) ||
           (act_taken && e.taken && (act_target != e.target));
  endfunction

  // Architecturally correct next PC after the resolved branch.
  function automatic logic [31:0] bru_next_pc(input bru_entry_t e,
                                              input logic act_taken,
                                              input logic [31:0] act_target);
    return act_taken ? act_target : (e.pc + 32'd4);
  endfunction

endpackage

// File: rtl/bru_pred_fifo.sv
// In-order FIFO of in-flight predictions. Pointers carry one extra wrap bit
// so full/empty are decided without a separate occupancy counter.
// Clear wins over a same-cycle push or pop.
module bru_pred_fifo
  import bru_pkg::*;
#(
  parameter int unsigned DEPTH = BRU_DEPTH_DEF
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       push_i,
  input  bru_entry_t entry_i,
  input  logic       pop_i,
  input  logic       clear_i,
  output logic       full_o,
  output logic       empty_o,
  output bru_entry_t head_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  bru_entry_t  mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        do_push_s, do_pop_s;

  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign head_o    = mem_q[rd_ptr_q[AW-1:0]];
  assign do_push_s = push_i && !full_o && !clear_i;
  assign do_pop_s  = pop_i && !empty_o && !clear_i;

  // Next-state pointer arithmetic.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
    end
  end

  // Pointer registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Entry storage; written only on an accepted push.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (do_push_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= entry_i;
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: pairs queued fetch predictions with ALU outcomes,
// flags mispredicts, redirects/flushes fetch and emits predictor training.
// Optional feature macro: BRU_STATS_EN adds saturating stat_branches and
// stat_mispredicts counters.
module branch_resolve_unit
  import bru_pkg::*;
#(
  parameter int unsigned DEPTH        = BRU_DEPTH_DEF,
  parameter int unsigned FLUSH_CYCLES = BRU_FLUSH_CYCLES_DEF,
  parameter int unsigned IDX_W        = BRU_IDX_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pred_valid,
  output logic             pred_ready,
  input  logic [31:0]      pred_pc,
  input  logic             pred_taken,
  input  logic [31:0]      pred_target,
  input  logic             ex_valid,
  input  logic             ex_taken,
  input  logic [31:0]      ex_target,
  output logic             upd_valid,
  output logic [IDX_W-1:0] upd_index,
  output logic             upd_taken,
  output logic             upd_pred,
  output logic             mispredict,
  output logic [31:0]      redirect_pc,
  output logic             flush,
`ifdef BRU_STATS_EN
  output logic [31:0]      stat_branches,
  output logic [31:0]      stat_mispredicts,
`endif
  output logic             underflow_err
);

  localparam int unsigned CW = $clog2(FLUSH_CYCLES + 1);
  localparam logic [CW-1:0] CNT_ONE    = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] FLUSH_INIT = CW'(FLUSH_CYCLES);

  bru_state_t      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            full_s, empty_s;
  bru_entry_t      head_s, new_entry_s;
  logic            push_s, pop_s, misp_s, underflow_s;

  logic             upd_valid_q;
  logic [IDX_W-1:0] upd_index_q;
  logic             upd_taken_q;
  logic             upd_pred_q;
  logic             mispredict_q;
  logic [31:0]      redirect_pc_q;
  logic             underflow_q;

  // Ready depends only on registered state so a full queue refuses a push
  // even when the head pops in the same cycle.
  assign pred_ready  = (state_q == RUN) && !full_s;
  assign flush       = (state_q == FLUSH);
  assign new_entry_s = '{pc: pred_pc, taken: pred_taken, target: pred_target};

  bru_pred_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk),
    .rst_ni  (reset),
    .push_i  (push_s),
    .entry_i (new_entry_s),
    .pop_i   (pop_s),
    .clear_i (misp_s),
    .full_o  (full_s),
    .empty_o (empty_s),
    .head_o  (head_s)
  );

  // Resolve/push decisions and RUN/FLUSH next-state logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    push_s      = 1'b0;
    pop_s       = 1'b0;
    misp_s      = 1'b0;
    underflow_s = 1'b0;
    case (state_q)
      RUN: begin
        if (ex_valid) begin
          if (!empty_s) begin
            pop_s  = 1'b1;
            misp_s = bru_is_mispredict(head_s, ex_taken, ex_target);
          end else begin
            underflow_s = 1'b1;
          end
        end else begin
          pop_s = 1'b0;
        end
        // Younger entries and any same-cycle push are wrong-path on a mispredict.
        if (misp_s) begin
          state_d = FLUSH;
          cnt_d   = FLUSH_INIT;
          push_s  = 1'b0;
        end else begin
          push_s  = pred_valid && pred_ready;
        end
      end
      FLUSH: begin
        if (cnt_q == CNT_ONE) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM state and flush counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Registered training strobe, mispredict pulse, redirect and sticky error.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      upd_valid_q   <= 1'b0;
      upd_index_q   <= '0;
      upd_taken_q   <= 1'b0;
      upd_pred_q    <= 1'b0;
      mispredict_q  <= 1'b0;
      redirect_pc_q <= 32'd0;
      underflow_q   <= 1'b0;
    end else begin
      upd_valid_q  <= pop_s;
      mispredict_q <= misp_s;
      if (pop_s) begin
        upd_index_q <= head_s.pc[IDX_W-1:0];
        upd_taken_q <= ex_taken;
        upd_pred_q  <= head_s.taken;
      end
      if (misp_s) begin
        redirect_pc_q <= bru_next_pc(head_s, ex_taken, ex_target);
      end
      if (underflow_s) begin
        underflow_q <= 1'b1;
      end
    end
  end

  assign upd_valid     = upd_valid_q;
  assign upd_index     = upd_index_q;
  assign upd_taken     = upd_taken_q;
  assign upd_pred      = upd_pred_q;
  assign mispredict    = mispredict_q;
  assign redirect_pc   = redirect_pc_q;
  assign underflow_err = underflow_q;

`ifdef BRU_STATS_EN
  logic [31:0] stat_branches_q, stat_mispredicts_q;

  // Saturating resolution and mispredict counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_branches_q    <= 32'd0;
      stat_mispredicts_q <= 32'd0;
    end else begin
      if (pop_s && (stat_branches_q != 32'hFFFF_FFFF)) begin
        stat_branches_q <= stat_branches_q + 32'd1;
      end
      if (misp_s && (stat_mispredicts_q != 32'hFFFF_FFFF)) begin
        stat_mispredicts_q <= stat_mispredicts_q + 32'd1;
      end
    end
  end

  assign stat_branches    = stat_branches_q;
  assign stat_mispredicts = stat_mispredicts_q;
`endif

endmodule
